// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU definitions for the instruction fetch unit: FSM state encoding,
// the NOP used as the reset instruction, and the sequential PC increment.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_HOLD = 2'b11
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] byte_addr);
        return byte_addr & ~32'd3;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding instruction fetch stage: requests one word at a time,
// presents it to decode until consumed, and squashes responses made stale by a redirect.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ADDR_BITS = 5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    output logic                 mem_read,
    output logic [ADDR_BITS-1:0] mem_address,
    input  logic [31:0]          mem_instruction,
    input  logic                 mem_busywait,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_target,
    output logic                 if_valid,
    output logic [31:0]          if_pc,
    output logic [31:0]          if_instruction
);

    fetch_state_e         state_q;
    logic [31:0]          pc_q;
    logic [31:0]          pc_d;
    logic                 mem_read_q;
    logic [ADDR_BITS-1:0] mem_addr_q;
    logic                 if_valid_q;
    logic [31:0]          if_pc_q;
    logic [31:0]          if_instr_q;
    logic                 squash_q;

    function automatic logic [ADDR_BITS-1:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr[ADDR_BITS+1:2];
    endfunction

    // A redirect wins in every state; otherwise the PC only advances when the
    // presented instruction is consumed.
    always_comb begin
        // NOTE: default first so every path assigns pc_d and no latch is inferred.
        pc_d = pc_q;
        if (branch_taken) begin
            pc_d = align_word(branch_target);
        end else if (state_q == ST_HOLD && !stall) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // The address is registered so it stays put during WAIT even when a
    // redirect has already moved the PC to the new target.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            mem_read_q <= 1'b0;
            mem_addr_q <= RESET_PC[ADDR_BITS+1:2];
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'h0000_0000;
            if_instr_q <= NOP_INSTR;
            squash_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            pc_q <= pc_d;
            case (state_q)
                ST_IDLE: begin
                    state_q    <= ST_REQ;
                    mem_read_q <= 1'b1;
                    mem_addr_q <= word_addr(pc_d);
                end
                ST_REQ: begin
                    if (branch_taken) begin
                        if_valid_q <= 1'b0;
                        mem_addr_q <= word_addr(pc_d);
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (branch_taken) begin
                        squash_q <= 1'b1;
                    end else if (!mem_busywait) begin
                        squash_q <= 1'b0;
                        if (squash_q) begin
                            // Stale response: drop it and go fetch the redirect target.
                            state_q    <= ST_REQ;
                            mem_addr_q <= word_addr(pc_q);
                        end else begin
                            state_q    <= ST_HOLD;
                            mem_read_q <= 1'b0;
                            if_valid_q <= 1'b1;
                            if_pc_q    <= pc_q;
                            if_instr_q <= mem_instruction;
                        end
                    end
                end
                ST_HOLD: begin
                    if (branch_taken || !stall) begin
                        state_q    <= ST_REQ;
                        mem_read_q <= 1'b1;
                        mem_addr_q <= word_addr(pc_d);
                        if_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_read       = mem_read_q;
    assign mem_address    = mem_addr_q;
    assign if_valid       = if_valid_q;
    assign if_pc          = if_pc_q;
    assign if_instruction = if_instr_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: transaction-level model compared
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        mem_read;
    logic [4:0]  mem_address;
    logic [31:0] mem_instruction;
    logic        mem_busywait = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;

    logic [31:0] mem_word [32];
    int total = 0;
    int bad = 0;

    instruction_fetch_unit #(.RESET_PC(RST_PC), .ADDR_BITS(5)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .mem_read       (mem_read),
        .mem_address    (mem_address),
        .mem_instruction(mem_instruction),
        .mem_busywait   (mem_busywait),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instruction (if_instruction)
    );

    always #5 clock = ~clock;

    assign mem_instruction = mem_word[mem_address];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: "busy" = an access is outstanding, "fresh" = it was issued
    // this cycle and cannot complete yet, "presenting" = an instruction awaits decode.
    logic        m_idle, m_busy, m_fresh, m_squash, m_presenting;
    logic [31:0] m_pc, m_ifpc, m_instr;
    logic [4:0]  m_addr;

    task automatic model_reset();
        m_idle = 1'b1; m_busy = 1'b0; m_fresh = 1'b0; m_squash = 1'b0;
        m_presenting = 1'b0; m_pc = RST_PC; m_ifpc = 32'h0; m_instr = NOP;
        m_addr = 5'(RST_PC >> 2);
    endtask

    task automatic model_issue();
        m_busy = 1'b1;
        m_fresh = 1'b1;
        m_addr = 5'(m_pc >> 2);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                model_reset();
            end else if (m_idle) begin
                if (branch_taken) m_pc = branch_target & ~32'd3;
                m_idle = 1'b0;
                model_issue();
            end else if (m_presenting) begin
                if (branch_taken || !stall) begin
                    m_pc = branch_taken ? (branch_target & ~32'd3) : m_pc + 32'd4;
                    m_presenting = 1'b0;
                    model_issue();
                end
            end else if (m_fresh) begin
                if (branch_taken) begin
                    m_pc = branch_target & ~32'd3;
                    model_issue();
                end else begin
                    m_fresh = 1'b0;
                end
            end else if (branch_taken) begin
                m_pc = branch_target & ~32'd3;
                m_squash = 1'b1;
            end else if (!mem_busywait) begin
                if (m_squash) begin
                    m_squash = 1'b0;
                    model_issue();
                end else begin
                    m_busy = 1'b0;
                    m_presenting = 1'b1;
                    m_ifpc = m_pc;
                    m_instr = mem_word[m_addr];
                end
            end
        end
    end

    always @(negedge clock) begin
        check("cyc_mem_read", 32'(mem_read), 32'(m_busy));
        check("cyc_mem_address", 32'(mem_address), 32'(m_addr));
        check("cyc_if_valid", 32'(if_valid), 32'(m_presenting));
        check("cyc_if_pc", if_pc, m_ifpc);
        check("cyc_if_instruction", if_instruction, m_instr);
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!if_valid && cycles < 50);
        check("wait_valid", 32'(if_valid), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_read"}, 32'(mem_read), 32'd0);
        check({tag, "_if_valid"}, 32'(if_valid), 32'd0);
        check({tag, "_if_pc"}, if_pc, 32'h0);
        check({tag, "_if_instruction"}, if_instruction, 32'h0000_0013);
        check({tag, "_mem_address"}, 32'(mem_address), 32'd0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 32; i++) mem_word[i] = 32'hC0DE_0000 + 32'(i);

        // Reset values and first fetch timing
        #1 reset_n = 1'b0;
        #2 check_reset_values("reset");
        tick();
        tick();
        reset_n = 1'b1;
        wait_valid(cyc);
        check("first_valid_cycle", 32'(cyc), 32'd3);
        check("fetch0_pc", if_pc, 32'h0);
        check("fetch0_instr", if_instruction, 32'hC0DE_0000);
        tick();
        check("fetch1_addr", 32'(mem_address), 32'd1);
        wait_valid(cyc);
        check("fetch1_pc", if_pc, 32'h4);
        tick();

        // Long busywait on address 2
        mem_busywait = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("busy_addr", 32'(mem_address), 32'd2);
            check("busy_read", 32'(mem_read), 32'd1);
        end
        mem_busywait = 1'b0;
        tick();
        check("busy_done_valid", 32'(if_valid), 32'd1);
        check("busy_done_instr", if_instruction, 32'hC0DE_0002);
        check("busy_done_pc", if_pc, 32'h8);

        // Stall in HOLD
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", 32'(if_valid), 32'd1);
            check("stall_pc", if_pc, 32'h8);
            check("stall_read", 32'(mem_read), 32'd0);
        end
        stall = 1'b0;
        tick();
        check("after_stall_addr", 32'(mem_address), 32'd3);
        check("after_stall_read", 32'(mem_read), 32'd1);

        // Branch during WAIT on address 5
        wait_valid(cyc);
        tick();
        wait_valid(cyc);
        tick();
        check("pre_branch_addr", 32'(mem_address), 32'd5);
        mem_busywait = 1'b1;
        tick();
        branch_taken = 1'b1; branch_target = 32'h0000_0041;
        tick();
        branch_taken = 1'b0;
        check("squash_addr_stable", 32'(mem_address), 32'd5);
        mem_busywait = 1'b0;
        tick();
        check("squash_valid", 32'(if_valid), 32'd0);
        check("squash_next_addr", 32'(mem_address), 32'd16);
        wait_valid(cyc);
        check("branch_pc", if_pc, 32'h40);
        check("branch_instr", if_instruction, 32'hC0DE_0010);

        // Branch beats stall in HOLD, then wrap from address 31
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_007C;
        tick();
        stall = 1'b0; branch_taken = 1'b0;
        check("hold_branch_valid", 32'(if_valid), 32'd0);
        check("hold_branch_addr", 32'(mem_address), 32'd31);
        wait_valid(cyc);
        check("wrap_src_pc", if_pc, 32'h7C);
        tick();
        check("wrap_addr", 32'(mem_address), 32'd0);
        wait_valid(cyc);
        check("wrap_pc", if_pc, 32'h80);
        check("wrap_instr", if_instruction, 32'hC0DE_0000);

        // Two branches during one squashed WAIT
        tick();
        mem_busywait = 1'b1;
        tick();
        branch_taken = 1'b1; branch_target = 32'h20;
        tick();
        branch_target = 32'h30;
        tick();
        branch_taken = 1'b0;
        check("double_br_addr_stable", 32'(mem_address), 32'd1);
        mem_busywait = 1'b0;
        tick();
        check("double_br_addr", 32'(mem_address), 32'd12);
        wait_valid(cyc);
        check("double_br_pc", if_pc, 32'h30);

        // Reset pulse mid-WAIT
        tick();
        mem_busywait = 1'b1;
        tick();
        #1 reset_n = 1'b0;
        #1 check_reset_values("midwait_reset");
        mem_busywait = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        wait_valid(cyc);
        check("restart_cycle", 32'(cyc), 32'd3);
        check("restart_pc", if_pc, RST_PC);

        // Branch in IDLE
        tick();
        #1 reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        branch_taken = 1'b1; branch_target = 32'h0000_0014;
        tick();
        branch_taken = 1'b0;
        check("idle_br_addr", 32'(mem_address), 32'd5);
        wait_valid(cyc);
        check("idle_br_pc", if_pc, 32'h14);

        // Branch in REQ
        tick();
        branch_taken = 1'b1; branch_target = 32'h0000_000B;
        tick();
        branch_taken = 1'b0;
        check("req_br_addr", 32'(mem_address), 32'd2);
        wait_valid(cyc);
        check("req_br_pc", if_pc, 32'h8);

        // Branch and completion on the same WAIT edge
        tick();
        tick();
        branch_taken = 1'b1; branch_target = 32'h0000_0050;
        tick();
        branch_taken = 1'b0;
        check("br_vs_done_valid", 32'(if_valid), 32'd0);
        check("br_vs_done_addr", 32'(mem_address), 32'd3);
        tick();
        check("br_vs_done_next", 32'(mem_address), 32'd20);
        wait_valid(cyc);
        check("br_vs_done_pc", if_pc, 32'h50);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
